// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - two-port round-robin front end for the iterative shift-add multiplier
// Grants one requester, captures its operands, runs WIDTH add/shift steps, returns a tagged product.
module mul_share_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 req1_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [2*WIDTH-1:0]   resp_result,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      count;
  logic               last_grant;
  logic               grant;
  logic               accept;

  // On contention the requester that did not win last time gets the slot.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && !grant && req0_valid;
  assign req1_ready = (state == IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  assign partial  = b_q[count] ? ({{WIDTH{1'b0}}, a_q} << count) : '0;
  assign acc_next = acc + partial;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      count       <= '0;
      last_grant  <= 1'b1;
      acc         <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q        <= grant ? req1_a : req0_a;
            b_q        <= grant ? req1_b : req0_b;
            acc        <= '0;
            count      <= '0;
            resp_id    <= grant;
            last_grant <= grant;
            state      <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          // Fixed-length loop: no early exit even when the multiplier runs out of ones.
          if (count == LAST) begin
            state       <= DONE;
            resp_valid  <= 1'b1;
            resp_result <= acc_next;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - directed self-checking bench for mul_share_ctrl
module tb_mul_share_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_ready, resp_id, busy;
  logic [15:0] resp_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_share_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b, input string tag);
    if (id) begin
      req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    #1;
    chk({tag, "_ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
    chk({tag, "_other_ready"}, 32'(id ? req0_ready : req1_ready), 32'd0);
    @(negedge clk);
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic finish_op(input logic id, input logic [15:0] res, input int exp_lat, input string tag);
    int lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_id"}, 32'(resp_id), 32'(id));
    chk({tag, "_result"}, 32'(resp_result), 32'(res));
    chk({tag, "_done_readies"}, 32'(req0_ready) + 32'(req1_ready), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    logic expg;
    reset = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_result", 32'(resp_result), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single request
    issue(1'b0, 8'd3, 8'd5, "single");
    chk("single_busy", 32'(busy), 32'd1);
    finish_op(1'b0, 16'd15, 8, "single");

    // contention straight out of reset: requester 0 first
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req1_a = 8'd7; req1_b = 8'd9; req1_valid = 1'b1;
    issue(1'b0, 8'd20, 8'd23, "cont0");
    finish_op(1'b0, 16'h01CC, 8, "cont0");
    issue(1'b1, 8'd7, 8'd9, "cont1");
    finish_op(1'b1, 16'd63, 8, "cont1");

    // fairness: both held valid for four operations
    req0_a = 8'd10; req0_b = 8'd11; req1_a = 8'd12; req1_b = 8'd13;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expg = (i % 2 == 1);
      #1;
      chk("fair_grant1", 32'(req1_ready), 32'(expg));
      chk("fair_grant0", 32'(req0_ready), 32'(!expg));
      @(negedge clk);
      finish_op(expg, expg ? 16'd156 : 16'd110, 8, "fair");
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // backpressure: hold DONE for 5 cycles with requester 1 waiting
    issue(1'b0, 8'd13, 8'd17, "bp");
    req1_a = 8'd4; req1_b = 8'd6; req1_valid = 1'b1;
    seen = 0;
    while (!resp_valid && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    chk("bp_latency", 32'(seen), 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_result", 32'(resp_result), 32'd221);
      chk("bp_hold_id", 32'(resp_id), 32'd0);
      chk("bp_hold_readies", 32'(req0_ready) + 32'(req1_ready), 32'd0);
    end
    finish_op(1'b0, 16'd221, 0, "bp");
    issue(1'b1, 8'd4, 8'd6, "bp_next");
    finish_op(1'b1, 16'd24, 8, "bp_next");

    // boundaries
    issue(1'b0, 8'd255, 8'd255, "max");
    finish_op(1'b0, 16'hFE01, 8, "max");
    issue(1'b1, 8'd0, 8'd200, "zero");
    finish_op(1'b1, 16'd0, 8, "zero");
    issue(1'b0, 8'd9, 8'd7, "hold_ops");
    req0_a = 8'd200; req0_b = 8'd200;
    finish_op(1'b0, 16'd63, 8, "hold_ops");

    // reset mid-RUN aborts the operation
    issue(1'b0, 8'd100, 8'd100, "abort");
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_result", 32'(resp_result), 32'd0);
    chk("abort_id", 32'(resp_id), 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    issue(1'b1, 8'd2, 8'd2, "post_abort");
    finish_op(1'b1, 16'd4, 8, "post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
Sequencing controller and two-port round-robin arbiter for the team's 8x8 shift-add multiplier datapath. Two requesters each present an operand pair with a valid/ready handshake. The block grants one requester, captures its operands, runs the iterative multiply for WIDTH cycles, and returns a tagged 2*WIDTH-bit product with a valid/ready handshake. It sits between the operand-entry logic (switch/button capture) and the hex display / result consumers.

Parameters:
WIDTH, 8, operand width; product width is 2*WIDTH, iteration count is WIDTH.

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operand pair
req0_a  input  WIDTH  requester 0 multiplicand
req0_b  input  WIDTH  requester 0 multiplier
req0_ready  output  1  requester 0 operands accepted this cycle if valid
req1_valid  input  1  requester 1 has an operand pair
req1_a  input  WIDTH  requester 1 multiplicand
req1_b  input  WIDTH  requester 1 multiplier
req1_ready  output  1  requester 1 operands accepted this cycle if valid
resp_valid  output  1  product available
resp_ready  input  1  consumer takes product this cycle
resp_id  output  1  requester the product belongs to
resp_result  output  2*WIDTH  unsigned product
busy  output  1  high in RUN or DONE

Behaviour:
- Single clock (clk). Reset is synchronous and active-high (reset), sampled only on posedge clk.
- Reset values: state=IDLE, resp_valid=0, resp_id=0, resp_result=0, busy=0, count=0, last_grant=1 (requester 0 wins the first contention).
- FSM states: IDLE, RUN, DONE.
- IDLE: grant is combinational. If only one valid, grant it. If both valid, grant the requester that is not last_grant. reqN_ready = (state==IDLE) && grant==N && reqN_valid. At most one ready is high per cycle. On accept edge, capture a and b, clear acc and count, set resp_id and last_grant to the granted id, and go to RUN.
- RUN: each edge, acc += (b[count] ? (a << count) : 0) at 2*WIDTH bits, then count++. On the edge where count==WIDTH-1, go to DONE. The loop always runs exactly WIDTH cycles with no early exit, including for zero operands.
- Latency: resp_valid rises exactly WIDTH cycles after the accept edge (8 for the default).
- DONE: resp_valid=1, resp_result=acc, resp_id stable. On an edge with resp_ready=1, go to IDLE and drop resp_valid. While resp_ready=0, hold everything and accept no new request (reqN_ready=0).
- No accept in the same cycle as a response handshake; the earliest next accept is the cycle after returning to IDLE.
- Operands are captured at accept. Later changes on reqN_a/b are ignored. A requester may drop valid before ready with no effect.
- Unsigned arithmetic; no overflow is possible (max 255*255 = 0xFE01 fits 16 bits).
- reset during RUN or DONE aborts the operation. No response is emitted, outputs return to reset values, and the next state is IDLE.
- busy = (state != IDLE).

Test Plan:
- Single request: after reset, req0 a=3 b=5 valid 1 cycle -> req0_ready=1 that cycle; resp_valid rises 8 cycles later with resp_result=15, resp_id=0; resp_ready=1 -> IDLE next cycle.
- Contention: both valid from reset, req0 (20,23), req1 (7,9) -> req0 granted first, result 460 (0x01CC) id 0; then req1 granted, result 63 id 1.
- Fairness: both valid continuously for 4 operations -> grant order 0,1,0,1. Grant never repeats while the other is waiting.
- Backpressure: resp_ready held low 5 cycles in DONE -> resp_valid, result and id are stable; req0_ready and req1_ready stay 0; accept occurs only after the handshake.
- Boundaries: 255*255 -> 0xFE01; 0*200 -> 0 after the full 8 cycles; operand change after accept -> result unchanged.
- Reset mid-RUN: assert reset at iteration 4 -> next cycle state IDLE, resp_valid=0, no response; a following req1 (2,2) -> 4, id 1.
